// File: rtl/shift_pkg.sv
// Types shared by the PISO serializer and the SIPO deserializer:
// the shift FSM state encoding and the bit-counter width helper.
package shift_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Room for WIDTH data bits plus an optional parity bit.
    function automatic int cnt_w(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter: synchronous clear, count enable and a
// terminal-count flag at NBITS-1. The count saturates there.
module piso_bit_counter
    import shift_pkg::*;
#(
    parameter int NBITS = 4,
    parameter int CW    = cnt_w(NBITS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_enable,
    output logic [CW-1:0] o_count,
    output logic          o_tc
);

    logic [CW-1:0] r_count;
    logic          w_tc;

    assign w_tc = (r_count == CW'(NBITS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_tc) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = w_tc;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer feeding the SIPO SI input.
// Define PISO_PARITY_EN to append one even-parity bit per frame.
module piso_serializer
    import shift_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] pdata,
    output logic             so,
    output logic             so_valid,
    output logic             frame_start,
    output logic             done
);

`ifdef PISO_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CW = cnt_w(WIDTH);

    state_e           r_state;
    state_e           w_next;
    logic [NBITS-1:0] r_shreg;
    logic [NBITS-1:0] w_frame;
    logic [NBITS-1:0] w_shifted;
    logic [CW-1:0]    w_count;
    logic             w_last;
    logic             w_accept;
    logic             w_shift;
    logic             w_clear;

    assign w_shift  = (r_state == SHIFT);
    assign w_accept = load_valid & load_ready;
    assign w_clear  = w_accept | (w_shift & w_last);

    piso_bit_counter #(
        .NBITS (NBITS),
        .CW    (CW)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_clear),
        .i_enable (w_shift),
        .o_count  (w_count),
        .o_tc     (w_last)
    );

`ifdef PISO_PARITY_EN
    logic w_parity;

    assign w_parity = ^pdata;

    // Parity always trails the data bits, whichever end goes first.
    always_comb begin
        w_frame = '0;
        if (LSB_FIRST != 0) begin
            w_frame = {w_parity, pdata};
        end else begin
            w_frame = {pdata, w_parity};
        end
    end
`else
    always_comb begin
        w_frame = pdata;
    end
`endif

    // Zero fill leaves the register clear once a frame is out.
    always_comb begin
        w_shifted = '0;
        if (LSB_FIRST != 0) begin
            w_shifted = {1'b0, r_shreg[NBITS-1:1]};
        end else begin
            w_shifted = {r_shreg[NBITS-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shreg <= '0;
        end else if (w_accept) begin
            r_shreg <= w_frame;
        end else if (w_shift) begin
            r_shreg <= w_shifted;
        end
    end

    assign so = (LSB_FIRST != 0) ? r_shreg[0] : r_shreg[NBITS-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last && !w_accept) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_comb begin
        load_ready  = 1'b0;
        so_valid    = 1'b0;
        frame_start = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            IDLE: begin
                load_ready = 1'b1;
            end
            SHIFT: begin
                so_valid    = 1'b1;
                frame_start = (w_count == '0);
                done        = w_last;
                load_ready  = w_last;
            end
            default: begin
                load_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer with a SIPO loopback model.
// Build with PISO_PARITY_EN to exercise the parity frame.
module tb_piso_serializer;

    localparam int WIDTH     = 4;
    localparam int LSB_FIRST = 1;
`ifdef PISO_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             load_valid = 1'b0;
    logic [WIDTH-1:0] pdata = '0;
    logic             load_ready;
    logic             so;
    logic             so_valid;
    logic             frame_start;
    logic             done;

    typedef struct {
        logic             so;
        logic             fs;
        logic             dn;
        logic             isdata;
        logic             lastd;
        logic [WIDTH-1:0] word;
    } exp_t;

    exp_t             q[$];
    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] sipo = '0;

    piso_serializer #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .pdata       (pdata),
        .so          (so),
        .so_valid    (so_valid),
        .frame_start (frame_start),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        exp_t e;
        for (int i = 0; i < NB; i++) begin
            e.word   = w;
            e.fs     = (i == 0);
            e.dn     = (i == NB - 1);
            e.isdata = (i < WIDTH);
            e.lastd  = (i == WIDTH - 1);
            if (i < WIDTH) begin
                e.so = w[(LSB_FIRST != 0) ? i : WIDTH - 1 - i];
            end else begin
                e.so = ^w;
            end
            q.push_back(e);
        end
    endtask

    // Monitor: SIPO-style sampling on the falling edge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (so_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bit: got so=%0b expected no bit", so);
            end else begin
                e = q.pop_front();
                check("bit{so,fs,done}", {5'd0, so, frame_start, done},
                      {5'd0, e.so, e.fs, e.dn});
                if (e.isdata) begin
                    if (LSB_FIRST != 0) begin
                        sipo = {so, sipo[WIDTH-1:1]};
                    end else begin
                        sipo = {sipo[WIDTH-2:0], so};
                    end
                end
                if (e.lastd) begin
                    check("sipo_po", {4'd0, sipo}, {4'd0, e.word});
                end
            end
        end else if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL gap: got so_valid=0 expected 1 (%0d bits pending)",
                     q.size());
        end
    end

    task automatic send(input logic [WIDTH-1:0] w);
        int n = 0;
        @(negedge clk);
        #1;
        load_valid = 1'b1;
        pdata      = w;
        while (!load_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!load_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got load_ready=0 expected 1");
            load_valid = 1'b0;
            return;
        end
        @(posedge clk);
        push_word(w);
        #1;
        load_valid = 1'b0;
    endtask

    task automatic drain_idle();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
            q.delete();
        end
        @(negedge clk);
        #1;
        check("idle_so_valid", {7'd0, so_valid}, 8'd0);
        check("idle_ready", {7'd0, load_ready}, 8'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with load_valid held high: nothing may be captured.
        reset      = 1'b0;
        load_valid = 1'b1;
        pdata      = 4'hF;
        #12;
        check("rst_so", {7'd0, so}, 8'd0);
        check("rst_so_valid", {7'd0, so_valid}, 8'd0);
        check("rst_done", {7'd0, done}, 8'd0);
        check("rst_fs", {7'd0, frame_start}, 8'd0);
        @(negedge clk);
        load_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rel_ready", {7'd0, load_ready}, 8'd1);
        check("rel_so_valid", {7'd0, so_valid}, 8'd0);

        // Single word: so = 1,1,0,1
        send(4'b1011);
        drain_idle();

        // Back-to-back: so = 0,1,0,1,1,0,1,0
        send(4'hA);
        send(4'h5);
        drain_idle();

        // Busy: 4'hF offered mid-frame is held off until the last bit
        send(4'h3);
        check("busy_ready", {7'd0, load_ready}, 8'd0);
        send(4'hF);
        drain_idle();

        // Reset after two bits of 4'hC
        send(4'hC);
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        sipo = '0;
        #1;
        check("abort_so_valid", {7'd0, so_valid}, 8'd0);
        check("abort_so", {7'd0, so}, 8'd0);
        check("abort_done", {7'd0, done}, 8'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready", {7'd0, load_ready}, 8'd1);
        check("abort_idle", {7'd0, so_valid}, 8'd0);
        send(4'hC);
        drain_idle();

        // Loopback of random words into the SIPO model
        for (int k = 0; k < 16; k++) begin
            send(WIDTH'($urandom_range(0, 15)));
        end
        drain_idle();

`ifdef PISO_PARITY_EN
        // 4'b0111 has odd weight: parity bit 1 as the fifth bit
        send(4'b0111);
        drain_idle();
`endif

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
